// File: rtl/accum_step_decoder_if.sv
// accum_step_decoder_if
//   Bundles the sample stream going into the step decoder and the recovered
//   step / lock status coming out of it.
//
//   master : drives sample_in, sample_valid, resync, clear_err;
//            observes step_out, step_valid, locked, mismatch, err_count
//   slave  : the decoder itself (the mirror image of master)
interface accum_step_decoder_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 8
);
  logic [WIDTH-1:0]     sample_in;
  logic                 sample_valid;
  logic                 resync;
  logic                 clear_err;
  logic [WIDTH-1:0]     step_out;
  logic                 step_valid;
  logic                 locked;
  logic                 mismatch;
  logic [ERR_WIDTH-1:0] err_count;

  modport master (
    output sample_in, sample_valid, resync, clear_err,
    input  step_out, step_valid, locked, mismatch, err_count
  );

  modport slave (
    input  sample_in, sample_valid, resync, clear_err,
    output step_out, step_valid, locked, mismatch, err_count
  );
endinterface

// File: rtl/accum_step_decoder.sv
// accum_step_decoder
//   Receiver for a running-sum accumulator. Each valid sample is subtracted
//   (modulo 2^WIDTH) from the previous one to recover the per-clock step.
//   After LOCK_COUNT identical steps in a row the block declares lock; a
//   differing step while locked raises a one-cycle mismatch pulse and bumps a
//   saturating error counter.
//
// Ports
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : accum_step_decoder_if.slave
//            sample_in / sample_valid : accumulator samples
//            resync                   : drop history, restart from EMPTY
//            clear_err                : zero err_count (wins over increment)
//            step_out / step_valid    : recovered step and its update pulse
//            locked                   : high while in LOCK
//            mismatch                 : one-cycle pulse on loss of lock
//            err_count                : saturating loss-of-lock count
module accum_step_decoder #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,   // legal range 1..15
  parameter int ERR_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  accum_step_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,  // no previous sample held
    PRIMED = 2'd1,  // previous sample held, no reference step yet
    TRACK  = 2'd2,  // counting identical steps toward lock
    LOCK   = 2'd3   // LOCK_COUNT identical steps seen
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     ref_q, ref_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     step_q, step_d;
  logic                 step_valid_q, step_valid_d;
  logic                 locked_q;
  logic                 mismatch_q, mismatch_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;

  logic [WIDTH-1:0]     delta;
  logic [3:0]           cnt_inc;

  // Plain wrap-around subtraction; the accumulator is free-running modulo
  // 2^WIDTH so no sign handling is wanted.
  assign delta   = bus.sample_in - prev_q;
  assign cnt_inc = cnt_q + 4'd1;

  // NOTE: every variable driven here gets its hold/default value first, so no
  // path through the if/case tree can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    ref_d        = ref_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    step_valid_d = 1'b0;
    mismatch_d   = 1'b0;

    if (bus.resync) begin
      // A sample arriving with resync is dropped on purpose.
      state_d = EMPTY;
      cnt_d   = 4'd0;
    end else if (bus.sample_valid) begin
      prev_d = bus.sample_in;
      case (state_q)
        EMPTY: begin
          state_d = PRIMED;
        end
        PRIMED: begin
          step_d       = delta;
          step_valid_d = 1'b1;
          ref_d        = delta;
          cnt_d        = 4'd1;
          state_d      = (LOCK_N == 4'd1) ? LOCK : TRACK;
        end
        TRACK: begin
          step_d       = delta;
          step_valid_d = 1'b1;
          if (delta == ref_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LOCK_N) state_d = LOCK;
          end else begin
            // Not locked yet, so a new step just restarts the run quietly.
            ref_d = delta;
            cnt_d = 4'd1;
          end
        end
        LOCK: begin
          step_d       = delta;
          step_valid_d = 1'b1;
          if (delta != ref_q) begin
            mismatch_d = 1'b1;
            ref_d      = delta;
            cnt_d      = 4'd1;
            state_d    = (LOCK_N == 4'd1) ? LOCK : TRACK;
          end
        end
      endcase
    end

    // clear_err beats a simultaneous increment; the mismatch pulse itself
    // is unaffected.
    err_d = err_q;
    if (bus.clear_err) begin
      err_d = '0;
    end else if (mismatch_d && (err_q != '1)) begin
      err_d = err_q + ERR_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      prev_q       <= '0;
      ref_q        <= '0;
      cnt_q        <= 4'd0;
      step_q       <= '0;
      step_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      ref_q        <= ref_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      step_valid_q <= step_valid_d;
      locked_q     <= (state_d == LOCK);
      mismatch_q   <= mismatch_d;
      err_q        <= err_d;
    end
  end

  assign bus.step_out   = step_q;
  assign bus.step_valid = step_valid_q;
  assign bus.locked     = locked_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.err_count  = err_q;

endmodule

// File: tb/tb_accum_step_decoder.sv
// tb_accum_step_decoder
//   Self-checking bench for accum_step_decoder: a hand-written vector table
//   for the basic lock / wrap / loss-of-lock behaviour, directed sequences for
//   valid gaps, resync, counter saturation and mid-run reset, and a random
//   phase compared against a run-length reference model.
module tb_accum_step_decoder;

  localparam int WIDTH      = 8;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_WIDTH  = 8;

  logic clk;
  logic reset;

  accum_step_decoder_if #(.WIDTH(WIDTH), .ERR_WIDTH(ERR_WIDTH)) bus ();

  accum_step_decoder #(
    .WIDTH     (WIDTH),
    .LOCK_COUNT(LOCK_COUNT),
    .ERR_WIDTH (ERR_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks history as "have a previous sample", "have a reference step" and
  // the length of the current run of identical steps; lock is simply
  // run >= LOCK_COUNT.
  bit       m_have_prev, m_have_ref;
  int       m_prev, m_ref, m_run, m_err;
  int       m_step;
  bit       m_valid, m_locked, m_mis;

  task automatic model_update(input bit rst, input bit v, input int s,
                              input bit rs, input bit clr);
    int  d;
    m_valid = 0;
    m_mis   = 0;
    if (rst) begin
      m_have_prev = 0; m_have_ref = 0; m_prev = 0; m_ref = 0;
      m_run = 0; m_err = 0; m_step = 0; m_locked = 0;
      return;
    end
    if (rs) begin
      m_have_prev = 0; m_have_ref = 0; m_run = 0; m_locked = 0;
    end else if (v) begin
      if (!m_have_prev) begin
        m_have_prev = 1;
        m_prev      = s;
      end else begin
        d       = (s - m_prev + 256) % 256;
        m_step  = d;
        m_valid = 1;
        m_prev  = s;
        if (m_have_ref && d == m_ref) begin
          m_run++;
        end else begin
          if (m_locked) begin
            m_mis = 1;
            if (m_err < 255) m_err++;
          end
          m_ref      = d;
          m_have_ref = 1;
          m_run      = 1;
        end
        m_locked = (m_run >= LOCK_COUNT);
      end
    end
    if (clr) m_err = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input bit rst, input bit v, input logic [7:0] s,
                      input bit rs, input bit clr);
    reset            = rst;
    bus.sample_valid = v;
    bus.sample_in    = s;
    bus.resync       = rs;
    bus.clear_err    = clr;
    @(posedge clk);
    model_update(rst, v, int'(s), rs, clr);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".step_out"},   32'(bus.step_out),   32'(m_step));
    check({tag, ".step_valid"}, 32'(bus.step_valid), 32'(m_valid));
    check({tag, ".locked"},     32'(bus.locked),     32'(m_locked));
    check({tag, ".mismatch"},   32'(bus.mismatch),   32'(m_mis));
    check({tag, ".err_count"},  32'(bus.err_count),  32'(m_err));
  endtask

  task automatic send(input logic [7:0] s, input string tag);
    tick(0, 1, s, 0, 0);
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    tick(0, 0, 8'h00, 0, 0);
    check_model(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst;
    bit         valid;
    logic [7:0] sample;
    bit         rs;
    bit         clr;
    logic [7:0] e_step;
    bit         e_valid;
    bit         e_locked;
    bit         e_mis;
    logic [7:0] e_err;
  } vec_t;

  function automatic vec_t vr(bit rst, bit v, logic [7:0] s, bit rs, bit clr,
                              logic [7:0] es, bit ev, bit el, bit em,
                              logic [7:0] ee);
    vec_t r;
    r.rst = rst; r.valid = v; r.sample = s; r.rs = rs; r.clr = clr;
    r.e_step = es; r.e_valid = ev; r.e_locked = el; r.e_mis = em; r.e_err = ee;
    return r;
  endfunction

  vec_t vecs[$];
  logic [7:0] acc;
  logic [7:0] cur_step;

  initial begin
    reset = 1'b1;
    bus.sample_in = '0; bus.sample_valid = 0; bus.resync = 0; bus.clear_err = 0;

    //          rst v  sample rs clr  step  sv lk mm err
    vecs.push_back(vr(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00)); // reset state
    vecs.push_back(vr(1, 1, 8'h33, 1, 1, 8'h00, 0, 0, 0, 8'h00)); // reset wins
    // clean lock on +3
    vecs.push_back(vr(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00));
    vecs.push_back(vr(0, 1, 8'h03, 0, 0, 8'h03, 1, 0, 0, 8'h00));
    vecs.push_back(vr(0, 1, 8'h06, 0, 0, 8'h03, 1, 0, 0, 8'h00));
    vecs.push_back(vr(0, 1, 8'h09, 0, 0, 8'h03, 1, 0, 0, 8'h00));
    vecs.push_back(vr(0, 1, 8'h0C, 0, 0, 8'h03, 1, 1, 0, 8'h00));
    vecs.push_back(vr(0, 1, 8'h0F, 0, 0, 8'h03, 1, 1, 0, 8'h00));
    // loss of lock on +5, then relock
    vecs.push_back(vr(0, 1, 8'h14, 0, 0, 8'h05, 1, 0, 1, 8'h01));
    vecs.push_back(vr(0, 1, 8'h19, 0, 0, 8'h05, 1, 0, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'h1E, 0, 0, 8'h05, 1, 0, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'h23, 0, 0, 8'h05, 1, 1, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'h28, 0, 0, 8'h05, 1, 1, 0, 8'h01));
    // resync then wrap-around on +0x18
    vecs.push_back(vr(0, 0, 8'h00, 1, 0, 8'h05, 0, 0, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'hE0, 0, 0, 8'h05, 0, 0, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'hF8, 0, 0, 8'h18, 1, 0, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'h10, 0, 0, 8'h18, 1, 0, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'h28, 0, 0, 8'h18, 1, 0, 0, 8'h01));
    vecs.push_back(vr(0, 1, 8'h40, 0, 0, 8'h18, 1, 1, 0, 8'h01));
    vecs.push_back(vr(0, 0, 8'h00, 0, 1, 8'h18, 0, 1, 0, 8'h00)); // clear_err
    vecs.push_back(vr(0, 1, 8'h55, 1, 0, 8'h18, 0, 0, 0, 8'h00)); // resync drops sample
    vecs.push_back(vr(0, 1, 8'h60, 0, 0, 8'h18, 0, 0, 0, 8'h00)); // EMPTY again
    vecs.push_back(vr(0, 1, 8'h60, 0, 0, 8'h00, 1, 0, 0, 8'h00)); // zero step

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].valid, vecs[i].sample, vecs[i].rs, vecs[i].clr);
      check($sformatf("vec%0d.step_out", i),   32'(bus.step_out),   32'(vecs[i].e_step));
      check($sformatf("vec%0d.step_valid", i), 32'(bus.step_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.locked", i),     32'(bus.locked),     32'(vecs[i].e_locked));
      check($sformatf("vec%0d.mismatch", i),   32'(bus.mismatch),   32'(vecs[i].e_mis));
      check($sformatf("vec%0d.err_count", i),  32'(bus.err_count),  32'(vecs[i].e_err));
    end

    // zero step keeps going and locks
    for (int i = 0; i < 3; i++) send(8'h60, "zero_step");
    check("zero_step.locked", 32'(bus.locked), 32'd1);

    // ---- valid gaps and resync, step 0x07 ----
    tick(0, 0, 8'h00, 1, 0);
    check_model("gap_resync0");
    acc = 8'h00;
    send(acc, "gap_prime");
    for (int k = 0; k < 5; k++) begin
      for (int g = 0; g < 3; g++) begin
        idle("gap_idle");
        check("gap_idle.step_valid", 32'(bus.step_valid), 32'd0);
      end
      acc = acc + 8'h07;
      send(acc, "gap_sample");
      check("gap_sample.step_out", 32'(bus.step_out), 32'h07);
    end
    check("gap.locked", 32'(bus.locked), 32'd1);
    tick(0, 0, 8'h00, 1, 0);
    check("gap_resync.locked", 32'(bus.locked), 32'd0);
    send(8'h40, "post_resync0");
    check("post_resync0.step_valid", 32'(bus.step_valid), 32'd0);
    send(8'h47, "post_resync1");
    check("post_resync1.step_valid", 32'(bus.step_valid), 32'd1);
    check("post_resync1.step_out",   32'(bus.step_out),   32'h07);

    // ---- saturation: alternate +5 / +3 runs of four samples ----
    acc = 8'h47;
    for (int i = 0; i < 300; i++) begin
      cur_step = (i % 2 == 0) ? 8'h05 : 8'h03;
      for (int j = 0; j < 4; j++) begin
        acc = acc + cur_step;
        send(acc, "sat");
      end
    end
    check("sat.err_count", 32'(bus.err_count), 32'hFF);
    check("sat.locked",    32'(bus.locked),    32'd1);
    // clear_err coincident with a mismatch
    acc = acc + 8'h05;
    tick(0, 1, acc, 0, 1);
    check_model("clr_mis");
    check("clr_mis.mismatch",  32'(bus.mismatch),  32'd1);
    check("clr_mis.err_count", 32'(bus.err_count), 32'd0);

    // ---- reset mid-operation while locked ----
    for (int j = 0; j < 3; j++) begin
      acc = acc + 8'h05;
      send(acc, "relock");
    end
    check("relock.locked", 32'(bus.locked), 32'd1);
    acc = acc + 8'h05;
    tick(1, 1, acc, 0, 0);
    check("midrst.step_out",   32'(bus.step_out),   32'd0);
    check("midrst.step_valid", 32'(bus.step_valid), 32'd0);
    check("midrst.locked",     32'(bus.locked),     32'd0);
    check("midrst.mismatch",   32'(bus.mismatch),   32'd0);
    check("midrst.err_count",  32'(bus.err_count),  32'd0);
    send(8'h10, "post_rst0");
    check("post_rst0.step_valid", 32'(bus.step_valid), 32'd0);
    send(8'h12, "post_rst1");
    check("post_rst1.step_out", 32'(bus.step_out), 32'h02);

    // ---- random phase against the model ----
    acc      = 8'h12;
    cur_step = 8'h02;
    for (int n = 0; n < 3000; n++) begin
      bit v, rs, clr, rst;
      v   = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 63) == 0);
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 511) == 0);
      if ($urandom_range(0, 9) == 0) cur_step = 8'($urandom_range(0, 255));
      if (v) acc = acc + cur_step;
      tick(rst, v, v ? acc : 8'($urandom_range(0, 255)), rs, clr);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_step_decoder.md
Name: accum_step_decoder

Overview:
- Receiver side of the running-sum accumulator output.
- Takes the 8-bit accumulator value sampled off the output pins and recovers the per-clock increment (step) as the modular difference between consecutive samples.
- Tracks whether the recovered step is stable, declares lock after a programmable run of identical steps, and counts loss-of-lock events for bring-up and silicon checkout.

Parameters:
- WIDTH, 8, width of accumulator samples and recovered step
- LOCK_COUNT, 4, consecutive identical steps required to declare lock; legal range 1..15
- ERR_WIDTH, 8, width of the saturating mismatch counter

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- sample_in  input  WIDTH  accumulator value
- sample_valid  input  1  sample_in is valid this cycle
- resync  input  1  discard history and return to EMPTY
- clear_err  input  1  zero err_count
- step_out  output  WIDTH  recovered step, registered
- step_valid  output  1  one-cycle pulse when step_out is updated
- locked  output  1  high while in LOCK
- mismatch  output  1  one-cycle pulse on loss of lock
- err_count  output  ERR_WIDTH  saturating loss-of-lock count

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - All outputs are 0, state is EMPTY, and prev, ref_step and match_cnt are 0.
  - reset overrides every other input.
- delta = (sample_in - prev) mod 2^WIDTH, a plain WIDTH-bit wrap-around subtraction with no sign handling. Example: prev=0xF0, sample=0x10 gives delta 0x20.
- Latency: step_out, step_valid, locked and mismatch are registered one cycle after the sample_valid edge that caused them.
- When sample_valid=0:
  - state, prev, ref_step and match_cnt hold.
  - step_valid=0 and mismatch=0.
  - step_out holds its last value.
- States (2-bit encoding):
  - EMPTY: on valid, prev<=sample_in and go to PRIMED. No step_valid.
  - PRIMED:
    - On valid: step_out<=delta, step_valid<=1, ref_step<=delta, match_cnt<=1, prev<=sample_in.
    - Go to LOCK if LOCK_COUNT==1, else to TRACK.
  - TRACK:
    - On valid: step_out<=delta, step_valid<=1, prev<=sample_in.
    - If delta==ref_step: match_cnt<=match_cnt+1. When match_cnt+1==LOCK_COUNT, go to LOCK.
    - Else: ref_step<=delta, match_cnt<=1. No mismatch pulse, because the block was not locked.
  - LOCK:
    - On valid: step_out<=delta, step_valid<=1, prev<=sample_in.
    - If delta==ref_step: stay in LOCK.
    - Else:
      - mismatch<=1 for one cycle.
      - err_count increments, saturating at all-ones.
      - ref_step<=delta, match_cnt<=1.
      - Go to TRACK (or stay in LOCK if LOCK_COUNT==1).
      - locked falls in the same cycle mismatch rises.
- locked = (state==LOCK), registered.
- resync:
  - Next state EMPTY; match_cnt<=0; locked<=0.
  - err_count is unaffected.
  - If resync and sample_valid are high together, the sample is dropped and no step_valid is produced.
- clear_err and an increment in the same cycle: clear wins, so err_count=0. The mismatch pulse still fires.
- Step value 0 (accumulator stuck) is a legal step and can lock.
- match_cnt is 4 bits and never exceeds LOCK_COUNT.

Test Plan:
- Clean lock, LOCK_COUNT=4: reset, then valid samples 0x00, 0x03, 0x06, 0x09, 0x0C, 0x0F on back-to-back cycles.
  - step_valid pulses with step_out=0x03 five times.
  - locked rises one cycle after the 5th sample (4th matching step) and stays high.
  - err_count=0.
- Wrap-around: samples 0xE0, 0xF8, 0x10, 0x28.
  - Steps 0x18, 0x18, 0x18.
  - No mismatch across the 0xF8→0x10 wrap.
- Loss of lock: lock on step 0x03, then sample prev+0x05.
  - step_out=0x05, mismatch pulses exactly one cycle, locked falls, err_count=1.
  - Four more +0x05 samples relock (locked high again).
- Valid gaps and resync: lock on step 0x07 with 3 idle cycles between samples.
  - Step results are unchanged and step_valid=0 during gaps.
  - Pulse resync: locked=0, and the next two samples 0x40, 0x47 give exactly one step_valid with 0x07.
- Saturation and clear: force 300 lock/mismatch cycles.
  - err_count holds at 0xFF.
  - clear_err coincident with a mismatch gives err_count=0 and mismatch=1.
- Reset mid-operation: assert reset while locked with step_valid pending.
  - Next cycle all outputs are 0 and state is EMPTY.
  - The first post-reset sample produces no step_valid.
